// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the frame buffer controller.
//   - fb_state_e : controller FSM states (WRITE / READ / DRAIN)
//   - fb_addr_w  : address width for a given frame depth
//   - default read latency and checksum width
package fb_pkg;

   typedef enum logic [1:0] {
      ST_WRITE = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } fb_state_e;

   localparam int FB_READ_LAT_DEF = 2;
   localparam int FB_CSUM_W_DEF   = 16;

   // Width of an address counter covering 0..depth-1.
   function automatic int fb_addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fb_bram_sdp.sv
// fb_bram_sdp: simple dual-port RAM, DATA_W x DEPTH, one write port and one
// read port, read data registered through READ_LAT stages.
// Ports:
//   clk_i            clock (rising edge)
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i     read issue; data appears on rdata_o READ_LAT cycles later
//   rdata_o          registered read data (not reset, qualified externally)
module fb_bram_sdp
   import fb_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 512,
   parameter int READ_LAT = FB_READ_LAT_DEF,
   parameter int AW       = fb_addr_w(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0]                mem_q [DEPTH];
   logic [READ_LAT-1:0][DATA_W-1:0]  pipe_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // First stage is the RAM output register; later stages free-run, the
   // controller's valid pipe says which beats are meaningful.
   always_ff @(posedge clk_i) begin
      if (re_i) pipe_q[0] <= mem_q[raddr_i];
      for (int k = 1; k < READ_LAT; k++) pipe_q[k] <= pipe_q[k-1];
   end

   assign rdata_o = pipe_q[READ_LAT-1];

endmodule

// File: rtl/frame_buffer_ctrl.sv
// frame_buffer_ctrl: single-frame store-and-forward buffer. Captures DEPTH
// valid pixels, then streams them back in address order with a valid strobe.
// Ports:
//   iClk, iRst (sync, active-low)
//   iData/iValid      pixel input, written only in WRITE
//   oData/oValid      pixel output (oData holds when oValid=0)
//   oFrameDone        pulse on the last output beat
//   oOverrun          pulse the cycle after iValid arrives outside WRITE
//   oBusy             high in READ and DRAIN
//   oMismatch         write/read checksum differ, valid with oFrameDone
// Optional feature: define FB_CHECKSUM_EN to build the checksum compare;
// otherwise oMismatch is constant 0.
module frame_buffer_ctrl
   import fb_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 512,
   parameter int READ_LAT = FB_READ_LAT_DEF,
   parameter int CSUM_W   = FB_CSUM_W_DEF
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic [DATA_W-1:0] iData,
   input  logic              iValid,
   output logic [DATA_W-1:0] oData,
   output logic              oValid,
   output logic              oFrameDone,
   output logic              oOverrun,
   output logic              oBusy,
   output logic              oMismatch
);

   localparam int            AW         = fb_addr_w(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
   localparam logic [2:0]    DRAIN_LAST = 3'(READ_LAT - 1);

   fb_state_e           state_q, state_d;
   logic [AW-1:0]       wr_addr_q, wr_addr_d;
   logic [AW-1:0]       rd_addr_q, rd_addr_d;
   logic [2:0]          drain_cnt_q, drain_cnt_d;
   logic                wr_en, rd_issue;
   logic [READ_LAT-1:0] vld_pipe_q, last_pipe_q;
   logic                overrun_q;
   logic [DATA_W-1:0]   rdata, hold_q;

   // State register
   always_ff @(posedge iClk) begin
      if (!iRst) begin
         state_q     <= ST_WRITE;
         wr_addr_q   <= '0;
         rd_addr_q   <= '0;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_addr_q   <= wr_addr_d;
         rd_addr_q   <= rd_addr_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   // Next state; counters wrap by explicit compare so DEPTH need not be 2^n
   always_comb begin
      state_d     = state_q;
      wr_addr_d   = wr_addr_q;
      rd_addr_d   = rd_addr_q;
      drain_cnt_d = drain_cnt_q;
      case (state_q)
         ST_WRITE: if (iValid) begin
            if (wr_addr_q == LAST_ADDR) begin
               wr_addr_d = '0;
               state_d   = ST_READ;
            end else begin
               wr_addr_d = wr_addr_q + 1'b1;
            end
         end
         ST_READ: begin
            if (rd_addr_q == LAST_ADDR) begin
               rd_addr_d   = '0;
               drain_cnt_d = '0;
               state_d     = ST_DRAIN;
            end else begin
               rd_addr_d = rd_addr_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (drain_cnt_q == DRAIN_LAST) begin
               drain_cnt_d = '0;
               state_d     = ST_WRITE;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_WRITE;
      endcase
   end

   // FSM outputs; the RAM write is blocked in a reset cycle
   always_comb begin
      wr_en    = 1'b0;
      rd_issue = 1'b0;
      oBusy    = 1'b0;
      case (state_q)
         ST_WRITE: wr_en = iValid & iRst;
         ST_READ: begin
            rd_issue = 1'b1;
            oBusy    = 1'b1;
         end
         ST_DRAIN: oBusy = 1'b1;
         default: ;
      endcase
   end

   fb_bram_sdp #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .READ_LAT (READ_LAT),
      .AW       (AW)
   ) u_ram (
      .clk_i   (iClk),
      .we_i    (wr_en),
      .waddr_i (wr_addr_q),
      .wdata_i (iData),
      .re_i    (rd_issue),
      .raddr_i (rd_addr_q),
      .rdata_o (rdata)
   );

   // Valid and last-beat flags ride alongside the RAM read pipeline
   always_ff @(posedge iClk) begin
      if (!iRst) begin
         vld_pipe_q  <= '0;
         last_pipe_q <= '0;
         overrun_q   <= 1'b0;
         hold_q      <= '0;
      end else begin
         vld_pipe_q[0]  <= rd_issue;
         last_pipe_q[0] <= rd_issue && (rd_addr_q == LAST_ADDR);
         for (int k = 1; k < READ_LAT; k++) begin
            vld_pipe_q[k]  <= vld_pipe_q[k-1];
            last_pipe_q[k] <= last_pipe_q[k-1];
         end
         overrun_q <= iValid && (state_q != ST_WRITE);
         if (oValid) hold_q <= rdata;
      end
   end

   assign oValid     = vld_pipe_q[READ_LAT-1];
   assign oFrameDone = last_pipe_q[READ_LAT-1];
   assign oOverrun   = overrun_q;
   // RAM pipe free-runs, so the last valid beat is held for idle cycles
   assign oData      = oValid ? rdata : hold_q;

`ifdef FB_CHECKSUM_EN
   logic [CSUM_W-1:0] wsum_q, rsum_q, rsum_beat;

   // Read sum including the current beat, so the compare covers the last pixel
   assign rsum_beat = rsum_q + CSUM_W'(rdata);

   always_ff @(posedge iClk) begin
      if (!iRst || oFrameDone) begin
         wsum_q <= '0;
         rsum_q <= '0;
      end else begin
         if (wr_en)  wsum_q <= wsum_q + CSUM_W'(iData);
         if (oValid) rsum_q <= rsum_beat;
      end
   end

   assign oMismatch = oFrameDone && (wsum_q != rsum_beat);
`else
   // Feature absent: constant 0 (CSUM_W is always positive)
   assign oMismatch = (CSUM_W < 0);
`endif

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
module tb_frame_buffer_ctrl;

   localparam int NCAP = 24;

   logic       clk = 1'b0;
   logic       rst_n, vld, vld2;
   logic [7:0] din, din2;
   logic [7:0] dout, dout2;
   logic       ov, fd, orun, busy, mis;
   logic       ov2, fd2, orun2, busy2, mis2;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   frame_buffer_ctrl #(.DATA_W(8), .DEPTH(16), .READ_LAT(2), .CSUM_W(16)) u_dut (
      .iClk(clk), .iRst(rst_n), .iData(din), .iValid(vld),
      .oData(dout), .oValid(ov), .oFrameDone(fd), .oOverrun(orun),
      .oBusy(busy), .oMismatch(mis)
   );

   frame_buffer_ctrl #(.DATA_W(8), .DEPTH(12), .READ_LAT(2), .CSUM_W(16)) u_dut12 (
      .iClk(clk), .iRst(rst_n), .iData(din2), .iValid(vld2),
      .oData(dout2), .oValid(ov2), .oFrameDone(fd2), .oOverrun(orun2),
      .oBusy(busy2), .oMismatch(mis2)
   );

   // per-cycle observations, index 0 = first cycle after the last write
   logic       r_vld [NCAP], r_fd [NCAP], r_busy [NCAP], r_orun [NCAP], r_mis [NCAP];
   logic [7:0] r_dat [NCAP];
   logic       r2_vld [NCAP], r2_fd [NCAP], r2_busy [NCAP];
   logic [7:0] r2_dat [NCAP];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // records outputs; optionally drives iValid=1/0xAA at cycle 'inj'
   task automatic capture(input int n, input int inj);
      for (int i = 0; i < n; i++) begin
         r_vld[i] = ov;  r_fd[i] = fd;  r_busy[i] = busy;
         r_orun[i] = orun; r_mis[i] = mis; r_dat[i] = dout;
         r2_vld[i] = ov2; r2_fd[i] = fd2; r2_busy[i] = busy2; r2_dat[i] = dout2;
         vld = (i == inj);
         din = (i == inj) ? 8'hAA : 8'h00;
         step();
      end
      vld = 1'b0;
   endtask

   // writes cnt pixels base, base+1, ...; gap inserts an idle cycle between writes
   task automatic write_frame(input logic [7:0] base, input bit gap, input int cnt);
      for (int k = 0; k < cnt; k++) begin
         vld = 1'b1;
         din = base + 8'(k);
         step();
         if (gap && k != cnt - 1) begin
            vld = 1'b0;
            step();
         end
      end
      vld = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; vld = 1'b0; vld2 = 1'b0; din = '0; din2 = '0;
      step(); step();
      for (int p = 0; p < 2; p++) begin
         n_chk++;
         if ({dout, ov, fd, orun, busy, mis} !== 13'd0 ||
             {dout2, ov2, fd2, orun2, busy2, mis2} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset phase %0d: got d=%h v=%b fd=%b ovr=%b busy=%b mis=%b d2=%h v2=%b busy2=%b, want all 0",
                     p, dout, ov, fd, orun, busy, mis, dout2, ov2, busy2);
         end
         rst_n = 1'b1;
         step();
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ed;
      write_frame(8'h00, 1'b0, 16);
      capture(20, -1);
      for (int i = 0; i < 20; i++) begin
         ed = (i < 18) ? 8'(i - 2) : 8'h0F;
         n_chk++;
         if (r_vld[i] !== (i >= 2 && i <= 17) || r_fd[i] !== (i == 17) ||
             r_busy[i] !== (i <= 17) || r_orun[i] !== 1'b0 || r_mis[i] !== 1'b0 ||
             (i >= 2 && r_dat[i] !== ed)) begin
            n_fail++;
            $display("FAIL b2b i=%0d: got v=%b d=%h fd=%b busy=%b ovr=%b mis=%b, want v=%b d=%h fd=%b busy=%b ovr=0 mis=0",
                     i, r_vld[i], r_dat[i], r_fd[i], r_busy[i], r_orun[i], r_mis[i],
                     (i >= 2 && i <= 17), ed, (i == 17), (i <= 17));
         end
      end
   endtask

   task automatic test_alternate();
      logic [7:0] ed;
      write_frame(8'h00, 1'b1, 15);
      n_chk++;
      if (busy !== 1'b0 || ov !== 1'b0) begin
         n_fail++;
         $display("FAIL alt_15_writes: got busy=%b v=%b, want busy=0 v=0", busy, ov);
      end
      step();
      write_frame(8'h0F, 1'b0, 1);
      capture(20, -1);
      for (int i = 0; i < 20; i++) begin
         ed = (i < 18) ? 8'(i - 2) : 8'h0F;
         n_chk++;
         if (r_vld[i] !== (i >= 2 && i <= 17) || r_fd[i] !== (i == 17) ||
             r_busy[i] !== (i <= 17) || (i >= 2 && r_dat[i] !== ed)) begin
            n_fail++;
            $display("FAIL alt i=%0d: got v=%b d=%h fd=%b busy=%b, want v=%b d=%h fd=%b busy=%b",
                     i, r_vld[i], r_dat[i], r_fd[i], r_busy[i],
                     (i >= 2 && i <= 17), ed, (i == 17), (i <= 17));
         end
      end
   endtask

   task automatic test_overrun();
      logic [7:0] base, ed;
      for (int f = 0; f < 2; f++) begin
         base = (f == 0) ? 8'h40 : 8'h10;
         write_frame(base, 1'b0, 16);
         capture(20, (f == 0) ? 3 : -1);
         for (int i = 0; i < 20; i++) begin
            ed = (i < 18) ? base + 8'(i - 2) : base + 8'h0F;
            n_chk++;
            if (r_vld[i] !== (i >= 2 && i <= 17) || r_fd[i] !== (i == 17) ||
                r_orun[i] !== (f == 0 && i == 4) || (i >= 2 && r_dat[i] !== ed)) begin
               n_fail++;
               $display("FAIL overrun f=%0d i=%0d: got v=%b d=%h fd=%b ovr=%b, want v=%b d=%h fd=%b ovr=%b",
                        f, i, r_vld[i], r_dat[i], r_fd[i], r_orun[i],
                        (i >= 2 && i <= 17), ed, (i == 17), (f == 0 && i == 4));
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] ed;
      write_frame(8'hE0, 1'b0, 5);
      rst_n = 1'b0;
      step();
      n_chk++;
      if ({dout, ov, fd, orun, busy, mis} !== 13'd0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got d=%h v=%b fd=%b ovr=%b busy=%b mis=%b, want all 0",
                  dout, ov, fd, orun, busy, mis);
      end
      rst_n = 1'b1;
      write_frame(8'h20, 1'b0, 15);
      n_chk++;
      if (busy !== 1'b0 || ov !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_15_writes: got busy=%b v=%b, want busy=0 v=0", busy, ov);
      end
      write_frame(8'h2F, 1'b0, 1);
      capture(20, -1);
      for (int i = 0; i < 20; i++) begin
         ed = (i < 18) ? 8'h20 + 8'(i - 2) : 8'h2F;
         n_chk++;
         if (r_vld[i] !== (i >= 2 && i <= 17) || r_fd[i] !== (i == 17) ||
             r_busy[i] !== (i <= 17) || (i >= 2 && r_dat[i] !== ed)) begin
            n_fail++;
            $display("FAIL midreset i=%0d: got v=%b d=%h fd=%b busy=%b, want v=%b d=%h fd=%b busy=%b",
                     i, r_vld[i], r_dat[i], r_fd[i], r_busy[i],
                     (i >= 2 && i <= 17), ed, (i == 17), (i <= 17));
         end
      end
   endtask

   task automatic test_depth12();
      int beats;
      for (int k = 0; k < 11; k++) begin
         vld2 = 1'b1; din2 = 8'(k); step();
      end
      vld2 = 1'b0;
      n_chk++;
      if (busy2 !== 1'b0) begin
         n_fail++;
         $display("FAIL d12_11_writes: got busy=%b, want 0", busy2);
      end
      vld2 = 1'b1; din2 = 8'd11; step();
      vld2 = 1'b0;
      capture(18, -1);
      beats = 0;
      for (int i = 0; i < 18; i++) begin
         if (r2_vld[i] === 1'b1) beats++;
         n_chk++;
         if (r2_vld[i] !== (i >= 2 && i <= 13) || r2_fd[i] !== (i == 13) ||
             r2_busy[i] !== (i <= 13) || (i >= 2 && i <= 13 && r2_dat[i] !== 8'(i - 2))) begin
            n_fail++;
            $display("FAIL d12 i=%0d: got v=%b d=%h fd=%b busy=%b, want v=%b d=%h fd=%b busy=%b",
                     i, r2_vld[i], r2_dat[i], r2_fd[i], r2_busy[i],
                     (i >= 2 && i <= 13), 8'(i - 2), (i == 13), (i <= 13));
         end
      end
      n_chk++;
      if (beats != 12) begin
         n_fail++;
         $display("FAIL d12_beats: got %0d, want 12", beats);
      end
   endtask

`ifdef FB_CHECKSUM_EN
   task automatic test_checksum();
      write_frame(8'h50, 1'b0, 16);
      capture(20, -1);
      n_chk++;
      if (r_fd[17] !== 1'b1 || r_mis[17] !== 1'b0) begin
         n_fail++;
         $display("FAIL csum_clean: got fd=%b mis=%b, want fd=1 mis=0", r_fd[17], r_mis[17]);
      end
      write_frame(8'h60, 1'b0, 16);
      for (int i = 0; i < 20; i++) begin
         if (i == 0) u_dut.u_ram.mem_q[3] = 8'hFF;
         r_fd[i] = fd; r_mis[i] = mis;
         step();
      end
      n_chk++;
      if (r_fd[17] !== 1'b1 || r_mis[17] !== 1'b1 || r_mis[16] !== 1'b0) begin
         n_fail++;
         $display("FAIL csum_corrupt: got fd=%b mis=%b mis_prev=%b, want fd=1 mis=1 mis_prev=0",
                  r_fd[17], r_mis[17], r_mis[16]);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_back_to_back();
      test_alternate();
      test_overrun();
      test_reset_midframe();
      test_depth12();
`ifdef FB_CHECKSUM_EN
      test_checksum();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
